// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: sequences IDLE/FETCH/DECODE/EXEC/MEM/WB with a memory wait timeout.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_write,
    output logic               pc_write,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               branch,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state_o,
    output logic               mem_error,
    output logic               illegal_instr,
    output logic [CNT_W-1:0]   retired
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
    } opClass_t;

    state_t            state, nextState;
    opClass_t          opClass, decClass;
    logic [WAIT_W-1:0] waitCnt;
    logic              waiting, timeoutHit, complete, useAlu;
    logic [1:0]        aluCode;

    always_comb begin
        case (opcode)
            7'b0110011: decClass = CLS_R;
            7'b0010011: decClass = CLS_I;
            7'b0000011: decClass = CLS_LOAD;
            7'b0100011: decClass = CLS_STORE;
            7'b1100011: decClass = CLS_BRANCH;
            default:    decClass = CLS_ILLEGAL;
        endcase
    end

    // Every exit from FETCH/MEM needs mem_ready (or goes to ERROR), so the counter is zero on entry.
    assign waiting    = ((state == FETCH) || (state == MEM)) && !mem_ready;
    assign timeoutHit = waiting && (waitCnt == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            opClass <= CLS_NOP;
            waitCnt <= '0;
            retired <= '0;
        end else begin
            state   <= nextState;
            if (state == DECODE) opClass <= decClass;
            waitCnt <= waiting ? waitCnt + WAIT_W'(1) : '0;
            if (complete) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        nextState = state;
        complete  = 1'b0;
        case (state)
            IDLE:   if (run) nextState = FETCH;
            FETCH: begin
                if (mem_ready)       nextState = DECODE;
                else if (timeoutHit) nextState = ERROR;
            end
            DECODE: begin
                if (decClass == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                    nextState = TRAP;
`else
                    complete  = 1'b1;
`endif
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                case (opClass)
                    CLS_BRANCH:          complete  = 1'b1;
                    CLS_LOAD, CLS_STORE: nextState = MEM;
                    default:             nextState = WB;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (opClass == CLS_LOAD) nextState = WB;
                    else                     complete  = 1'b1;
                end else if (timeoutHit) begin
                    nextState = ERROR;
                end
            end
            WB:      complete = 1'b1;
            default: nextState = state;
        endcase
        if (complete) nextState = run ? FETCH : IDLE;
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        mem_error  = 1'b0;
        useAlu     = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            DECODE: pc_write = 1'b1;
            EXEC: begin
                useAlu = 1'b1;
                branch = (opClass == CLS_BRANCH);
            end
            MEM: begin
                useAlu  = 1'b1;
                mem_req = 1'b1;
                mem_we  = (opClass == CLS_STORE);
            end
            WB: begin
                useAlu     = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = (opClass == CLS_LOAD);
            end
            ERROR:   mem_error = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        alu_src = 1'b0;
        aluCode = 2'b00;
        if (useAlu) begin
            case (opClass)
                CLS_R:               aluCode = 2'b10;
                CLS_I:     begin alu_src = 1'b1; aluCode = 2'b11; end
                CLS_LOAD,
                CLS_STORE: begin alu_src = 1'b1; aluCode = 2'b00; end
                CLS_BRANCH:          aluCode = 2'b01;
                default: ;
            endcase
        end
        alu_op = ALUOP_W'(aluCode);
    end

    assign state_o = state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state == TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction phase plans built from the
// instruction-class rules, driven with randomized don't-care inputs and compared cycle by cycle.
`timescale 1ns/1ps
module tb_multicycle_control;
    localparam int unsigned ALUOP_W     = 3;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_ERROR = 3'd6, ST_TRAP = 3'd7;

    logic               clock = 1'b0;
    logic               reset, run, mem_ready;
    logic [6:0]         opcode;
    logic               mem_req, mem_we, ir_write, pc_write, alu_src, mem_to_reg, reg_write, branch;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         state_o;
    logic               mem_error, illegal_instr;
    logic [CNT_W-1:0]   retired;
    logic [12:0]        ctrl;

    multicycle_control #(
        .ALUOP_W(ALUOP_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
        .alu_op(alu_op), .state_o(state_o), .mem_error(mem_error),
        .illegal_instr(illegal_instr), .retired(retired)
    );

    // [12]req [11]we [10]ir_write [9]pc_write [8]alu_src [7]mem_to_reg [6]reg_write [5]branch
    // [4:2]alu_op [1]mem_error [0]illegal_instr
    assign ctrl = {mem_req, mem_we, ir_write, pc_write, alu_src, mem_to_reg, reg_write, branch,
                   alu_op, mem_error, illegal_instr};

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] st;
        logic       rdy;
        logic       rn;
        logic [6:0] opc;
        logic [6:0] cls;
    } entry_t;

    entry_t           plan[$];
    entry_t           ran[$];
    logic [2:0]       obsSt[$];
    logic [12:0]      obsCtrl[$];
    logic [CNT_W-1:0] obsRet[$];
    int               tests = 0;
    int               fails = 0;
    int               expRetired = 0;
    bit               inIdle = 1'b1;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic logic [CNT_W-1:0] expRet();
        return CNT_W'(expRetired % (1 << CNT_W));
    endfunction

    function automatic logic isLegal(input logic [6:0] o);
        return (o == OP_R) || (o == OP_I) || (o == OP_LD) || (o == OP_ST) || (o == OP_BR);
    endfunction

    // {alu_src, alu_op} per instruction class
    function automatic logic [3:0] aluFields(input logic [6:0] o);
        case (o)
            OP_R:         return 4'b0010;
            OP_I:         return 4'b1011;
            OP_LD, OP_ST: return 4'b1000;
            OP_BR:        return 4'b0001;
            default:      return 4'b0000;
        endcase
    endfunction

    function automatic logic [12:0] expCtrl(input logic [2:0] st, input logic [6:0] cls, input logic rdy);
        logic [12:0] v;
        logic [3:0]  a;
        v = '0;
        a = aluFields(cls);
        case (st)
            ST_FETCH:  begin v[12] = 1'b1; v[10] = rdy; end
            ST_DECODE: v[9] = 1'b1;
            ST_EXEC:   begin v[8] = a[3]; v[4:2] = a[2:0]; v[5] = (cls == OP_BR); end
            ST_MEM:    begin v[8] = a[3]; v[4:2] = a[2:0]; v[12] = 1'b1; v[11] = (cls == OP_ST); end
            ST_WB:     begin v[8] = a[3]; v[4:2] = a[2:0]; v[6] = 1'b1; v[7] = (cls == OP_LD); end
            ST_ERROR:  v[1] = 1'b1;
            ST_TRAP:   v[0] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] randOpc();
        logic [6:0]  o;
        int unsigned k;
`ifdef ILLEGAL_TRAP_EN
        k = $urandom_range(0, 4);
`else
        k = $urandom_range(0, 5);
`endif
        case (k)
            0: o = OP_R;
            1: o = OP_I;
            2: o = OP_LD;
            3: o = OP_ST;
            4: o = OP_BR;
            default: begin
                o = r7();
                while (isLegal(o)) o = r7();
            end
        endcase
        return o;
    endfunction

    task automatic cyc(input logic rdy, input logic rn, input logic [6:0] opc);
        @(negedge clock);
        mem_ready = rdy;
        run       = rn;
        opcode    = opc;
        #1;
    endtask

    task automatic pushEntry(input logic [2:0] st, input logic rdy, input logic rn,
                             input logic [6:0] opc, input logic [6:0] cls);
        entry_t e;
        e.st = st; e.rdy = rdy; e.rn = rn; e.opc = opc; e.cls = cls;
        plan.push_back(e);
    endtask

    // Phase sequence of one instruction; mem_ready is low for waitF/waitM cycles in FETCH/MEM.
    task automatic makePlan(input logic [6:0] cls, input int unsigned waitF, input int unsigned waitM,
                            input logic runEnd, input int unsigned idleExtra);
        entry_t e;
        if (inIdle) begin
            for (int unsigned i = 0; i < idleExtra; i++) pushEntry(ST_IDLE, rb(), 1'b0, r7(), cls);
            pushEntry(ST_IDLE, rb(), 1'b1, r7(), cls);
        end
        for (int unsigned i = 0; i < waitF; i++) pushEntry(ST_FETCH, 1'b0, rb(), r7(), cls);
        pushEntry(ST_FETCH, 1'b1, rb(), r7(), cls);
        pushEntry(ST_DECODE, rb(), rb(), cls, cls);
        if (isLegal(cls)) begin
            pushEntry(ST_EXEC, rb(), rb(), r7(), cls);
            if (cls == OP_LD || cls == OP_ST) begin
                for (int unsigned i = 0; i < waitM; i++) pushEntry(ST_MEM, 1'b0, rb(), r7(), cls);
                pushEntry(ST_MEM, 1'b1, rb(), r7(), cls);
            end
            if (cls == OP_R || cls == OP_I || cls == OP_LD) pushEntry(ST_WB, rb(), rb(), r7(), cls);
        end
`ifdef ILLEGAL_TRAP_EN
        if (!isLegal(cls)) begin
            inIdle = 1'b0;
            return;
        end
`endif
        e = plan.pop_back();
        e.rn = runEnd;
        plan.push_back(e);
        inIdle = !runEnd;
    endtask

    task automatic execPlan();
        obsSt.delete(); obsCtrl.delete(); obsRet.delete();
        ran = plan;
        plan.delete();
        foreach (ran[i]) begin
            cyc(ran[i].rdy, ran[i].rn, ran[i].opc);
            obsSt.push_back(state_o);
            obsCtrl.push_back(ctrl);
            obsRet.push_back(retired);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) cyc(rb(), 1'b0, r7());
        reset = 1'b0;
        inIdle = 1'b1;
        expRetired = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(rb(), (i < 2), r7());
            tests++; if (state_o !== ST_IDLE) begin fails++; $display("FAIL reset_state[%0d]: got %0d, expected 0", i, state_o); end
            tests++; if (ctrl !== '0) begin fails++; $display("FAIL reset_ctrl[%0d]: got %0h, expected 0", i, ctrl); end
            tests++; if (retired !== '0) begin fails++; $display("FAIL reset_retired[%0d]: got %0d, expected 0", i, retired); end
        end
        reset = 1'b0;
        inIdle = 1'b1;
        expRetired = 0;
    endtask

    task automatic test_rtype();
        logic [2:0] expSt[9];
        expSt = '{ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
        makePlan(OP_R, 0, 0, 1'b1, 0);
        makePlan(OP_R, 0, 0, 1'b1, 0);
        execPlan();
        for (int i = 0; i < 9; i++) begin
            tests++; if (obsSt[i] !== expSt[i]) begin fails++; $display("FAIL rtype_state[%0d]: got %0d, expected %0d", i, obsSt[i], expSt[i]); end
            tests++; if (obsCtrl[i][6] !== (expSt[i] == ST_WB)) begin fails++; $display("FAIL rtype_reg_write[%0d]: got %0b, expected %0b", i, obsCtrl[i][6], expSt[i] == ST_WB); end
        end
        tests++; if (obsCtrl[1][10] !== 1'b1) begin fails++; $display("FAIL rtype_ir_write: got %0b, expected 1", obsCtrl[1][10]); end
        tests++; if (obsCtrl[3][4:2] !== 3'b010) begin fails++; $display("FAIL rtype_alu_op: got %0b, expected 010", obsCtrl[3][4:2]); end
        tests++; if (obsRet[0] !== expRet()) begin fails++; $display("FAIL rtype_retired0: got %0d, expected %0d", obsRet[0], expRet()); end
        expRetired++;
        tests++; if (obsRet[5] !== expRet()) begin fails++; $display("FAIL rtype_retired1: got %0d, expected %0d", obsRet[5], expRet()); end
        expRetired++;
    endtask

    task automatic test_load();
        int memCnt;
        int last;
        memCnt = 0;
        makePlan(OP_LD, 0, 2, 1'b1, 0);
        execPlan();
        foreach (ran[i]) begin
            tests++; if (obsSt[i] !== ran[i].st) begin fails++; $display("FAIL load_state[%0d]: got %0d, expected %0d", i, obsSt[i], ran[i].st); end
            tests++; if (obsCtrl[i][11] !== 1'b0) begin fails++; $display("FAIL load_mem_we[%0d]: got %0b, expected 0", i, obsCtrl[i][11]); end
            if (obsSt[i] == ST_MEM) memCnt++;
        end
        tests++; if (memCnt != 3) begin fails++; $display("FAIL load_mem_cycles: got %0d, expected 3", memCnt); end
        last = ran.size() - 1;
        tests++; if (obsCtrl[last][8:6] !== 3'b111) begin fails++; $display("FAIL load_wb_ctrl: got src/m2r/rw=%0b, expected 111", obsCtrl[last][8:6]); end
        expRetired++;
    endtask

    task automatic test_store();
        int last;
        makePlan(OP_ST, 1, 1, 1'b0, 0);
        pushEntry(ST_IDLE, rb(), 1'b0, r7(), OP_ST);
        pushEntry(ST_IDLE, rb(), 1'b0, r7(), OP_ST);
        execPlan();
        foreach (ran[i]) begin
            tests++; if (obsSt[i] !== ran[i].st) begin fails++; $display("FAIL store_state[%0d]: got %0d, expected %0d", i, obsSt[i], ran[i].st); end
            tests++; if (obsCtrl[i][11] !== (ran[i].st == ST_MEM)) begin fails++; $display("FAIL store_mem_we[%0d]: got %0b, expected %0b", i, obsCtrl[i][11], ran[i].st == ST_MEM); end
            tests++; if (obsCtrl[i][6] !== 1'b0) begin fails++; $display("FAIL store_reg_write[%0d]: got %0b, expected 0", i, obsCtrl[i][6]); end
        end
        expRetired++;
        last = ran.size() - 1;
        tests++; if (obsRet[last] !== expRet()) begin fails++; $display("FAIL store_retired: got %0d, expected %0d", obsRet[last], expRet()); end
    endtask

    task automatic test_branch();
        int brCnt;
        brCnt = 0;
        makePlan(OP_BR, 0, 0, 1'b1, 1);
        makePlan(OP_R, 0, 0, 1'b1, 0);
        execPlan();
        foreach (ran[i]) begin
            tests++; if (obsSt[i] !== ran[i].st) begin fails++; $display("FAIL branch_state[%0d]: got %0d, expected %0d", i, obsSt[i], ran[i].st); end
            if (obsCtrl[i][5]) brCnt++;
        end
        tests++; if (brCnt != 1) begin fails++; $display("FAIL branch_pulses: got %0d, expected 1", brCnt); end
        tests++; if (obsCtrl[4] !== expCtrl(ST_EXEC, OP_BR, 1'b0)) begin fails++; $display("FAIL branch_exec_ctrl: got %0h, expected %0h", obsCtrl[4], expCtrl(ST_EXEC, OP_BR, 1'b0)); end
        expRetired++;
        tests++; if (obsRet[5] !== expRet()) begin fails++; $display("FAIL branch_retired: got %0d, expected %0d", obsRet[5], expRet()); end
        expRetired++;
    endtask

    task automatic test_random();
        logic [6:0] cls;
        for (int n = 0; n < 40; n++) begin
            cls = randOpc();
            makePlan(cls, $urandom_range(0, MEM_TIMEOUT), $urandom_range(0, MEM_TIMEOUT),
                     ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
            execPlan();
            foreach (ran[i]) begin
                tests++; if (obsSt[i] !== ran[i].st) begin fails++; $display("FAIL rand_state[%0d.%0d]: got %0d, expected %0d", n, i, obsSt[i], ran[i].st); end
                tests++; if (obsCtrl[i] !== expCtrl(ran[i].st, ran[i].cls, ran[i].rdy)) begin fails++; $display("FAIL rand_ctrl[%0d.%0d]: got %0h, expected %0h", n, i, obsCtrl[i], expCtrl(ran[i].st, ran[i].cls, ran[i].rdy)); end
                tests++; if (obsRet[i] !== expRet()) begin fails++; $display("FAIL rand_retired[%0d.%0d]: got %0d, expected %0d", n, i, obsRet[i], expRet()); end
            end
            expRetired++;
        end
    endtask

    task automatic test_wrap();
        doReset();
        for (int n = 0; n < 17; n++) begin
            makePlan(OP_R, 0, 0, 1'b1, 0);
            execPlan();
            tests++; if (obsRet[0] !== expRet()) begin fails++; $display("FAIL wrap_retired[%0d]: got %0d, expected %0d", n, obsRet[0], expRet()); end
            expRetired++;
        end
    endtask

    task automatic test_illegal();
        int off;
        off = inIdle ? 1 : 0;
        makePlan(OP_BAD, 0, 0, 1'b1, 0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) pushEntry(ST_TRAP, rb(), rb(), r7(), OP_BAD);
        execPlan();
        tests++; if (obsCtrl[off + 1][9] !== 1'b1) begin fails++; $display("FAIL illegal_pc_write: got %0b, expected 1", obsCtrl[off + 1][9]); end
        for (int i = off + 2; i < ran.size(); i++) begin
            tests++; if (obsSt[i] !== ST_TRAP) begin fails++; $display("FAIL trap_state[%0d]: got %0d, expected 7", i, obsSt[i]); end
            tests++; if (obsCtrl[i] !== 13'h1) begin fails++; $display("FAIL trap_ctrl[%0d]: got %0h, expected 1", i, obsCtrl[i]); end
            tests++; if (obsRet[i] !== expRet()) begin fails++; $display("FAIL trap_retired[%0d]: got %0d, expected %0d", i, obsRet[i], expRet()); end
        end
        doReset();
        cyc(rb(), 1'b0, r7());
        tests++; if ({state_o, illegal_instr} !== 4'b0000) begin fails++; $display("FAIL trap_reset: got state=%0d ill=%0b, expected 0/0", state_o, illegal_instr); end
`else
        makePlan(OP_R, 0, 0, 1'b1, 0);
        execPlan();
        foreach (ran[i]) begin
            tests++; if (obsSt[i] !== ran[i].st) begin fails++; $display("FAIL illegal_state[%0d]: got %0d, expected %0d", i, obsSt[i], ran[i].st); end
            tests++; if (obsCtrl[i] !== expCtrl(ran[i].st, ran[i].cls, ran[i].rdy)) begin fails++; $display("FAIL illegal_ctrl[%0d]: got %0h, expected %0h", i, obsCtrl[i], expCtrl(ran[i].st, ran[i].cls, ran[i].rdy)); end
        end
        expRetired++;
        tests++; if (obsRet[off + 2] !== expRet()) begin fails++; $display("FAIL illegal_retired: got %0d, expected %0d", obsRet[off + 2], expRet()); end
        expRetired++;
`endif
    endtask

    task automatic test_async_reset();
        doReset();
        makePlan(OP_R, 0, 0, 1'b1, 0);
        execPlan();
        cyc(1'b1, rb(), r7());
        cyc(rb(), rb(), OP_LD);
        cyc(rb(), rb(), r7());
        cyc(1'b0, rb(), r7());
        tests++; if ({state_o, retired} !== {ST_MEM, CNT_W'(1)}) begin fails++; $display("FAIL async_pre: got state=%0d ret=%0d, expected 4/1", state_o, retired); end
        reset = 1'b1;
        #1;
        tests++; if ({state_o, ctrl, retired} !== '0) begin fails++; $display("FAIL async_reset: got state=%0d ctrl=%0h ret=%0d, expected 0/0/0", state_o, ctrl, retired); end
        cyc(rb(), 1'b0, r7());
        reset = 1'b0;
        inIdle = 1'b1;
        expRetired = 0;
    endtask

    task automatic test_timeout();
        doReset();
        makePlan(OP_R, MEM_TIMEOUT, 0, 1'b0, 0);
        makePlan(OP_LD, 0, MEM_TIMEOUT, 1'b0, 0);
        execPlan();
        foreach (ran[i]) begin
            tests++; if (obsSt[i] !== ran[i].st) begin fails++; $display("FAIL limit_state[%0d]: got %0d, expected %0d", i, obsSt[i], ran[i].st); end
            tests++; if (obsCtrl[i] !== expCtrl(ran[i].st, ran[i].cls, ran[i].rdy)) begin fails++; $display("FAIL limit_ctrl[%0d]: got %0h, expected %0h", i, obsCtrl[i], expCtrl(ran[i].st, ran[i].cls, ran[i].rdy)); end
        end
        expRetired += 2;
        cyc(rb(), 1'b1, r7());
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            cyc(1'b0, rb(), r7());
            tests++; if (state_o !== ST_FETCH) begin fails++; $display("FAIL fetch_wait[%0d]: got %0d, expected 1", i, state_o); end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(rb(), rb(), r7());
            tests++; if (state_o !== ST_ERROR) begin fails++; $display("FAIL error_state[%0d]: got %0d, expected 6", i, state_o); end
            tests++; if (ctrl !== 13'h2) begin fails++; $display("FAIL error_ctrl[%0d]: got %0h, expected 2", i, ctrl); end
            tests++; if (retired !== expRet()) begin fails++; $display("FAIL error_retired[%0d]: got %0d, expected %0d", i, retired, expRet()); end
        end
        reset = 1'b1;
        #1;
        tests++; if ({state_o, mem_error} !== 4'b0000) begin fails++; $display("FAIL error_reset: got state=%0d err=%0b, expected 0/0", state_o, mem_error); end
        cyc(rb(), 1'b0, r7());
        reset = 1'b0;
        expRetired = 0;
        cyc(rb(), 1'b1, r7());
        cyc(1'b1, rb(), r7());
        cyc(rb(), rb(), OP_ST);
        cyc(rb(), rb(), r7());
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            cyc(1'b0, rb(), r7());
            tests++; if ({state_o, mem_we} !== {ST_MEM, 1'b1}) begin fails++; $display("FAIL mem_wait[%0d]: got state=%0d we=%0b, expected 4/1", i, state_o, mem_we); end
        end
        cyc(rb(), rb(), r7());
        tests++; if ({state_o, ctrl, retired} !== {ST_ERROR, 13'h2, CNT_W'(0)}) begin fails++; $display("FAIL mem_timeout: got state=%0d ctrl=%0h ret=%0d, expected 6/2/0", state_o, ctrl, retired); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch();
        test_random();
        test_wrap();
        test_illegal();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
